// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent compare timers on the CPU memory bus.
// Each channel has its own COMPARE, CTRL, COUNT and PRESCALE words. Every
// channel has a sticky pending flag, and the flag is masked by that
// channel's irq_en to form the interrupt.
//
// Optional feature: define MULTI_TIMER_PRESCALER_EN to add a per-channel
// prescaler. Without it, every channel ticks on every clk.
//
// Ports:
//   clk          system clock
//   resetq       asynchronous active-low reset
//   select       chip-select from the top-level address decode
//   wr           byte write mask; a bus write is select && wr != 0
//   addr         word address: [ADDR_W-1:2] selects the channel, [1:0] the register
//   data_in      write data
//   data_out     read data, combinational from addr
//   irq_pending  per-channel sticky pending flags
//   interrupt    OR over channels of (pending & irq_en)
module multi_timer #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PS_WIDTH = 16,
  parameter int unsigned ADDR_W   = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              select,
  input  logic [3:0]        wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic [NUM_CH-1:0] irq_pending,
  output logic              interrupt
);

  localparam int unsigned CH_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  localparam logic [1:0] REG_COMPARE  = 2'd0;
  localparam logic [1:0] REG_CTRL     = 2'd1;
  localparam logic [1:0] REG_COUNT    = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  // Elaboration-time parameter range check
  if (NUM_CH < 1 || NUM_CH > 16 || WIDTH < 8 || WIDTH > 32 ||
      PS_WIDTH < 1 || PS_WIDTH > 32) begin : g_param_check
    $error("multi_timer: parameter out of range");
  end

  // Address decode
  logic [CH_W-1:0] w_ch;
  logic [1:0]      w_reg;
  logic            w_ch_valid;
  logic            w_wr;

  if (ADDR_W > 2) begin : g_ch_field
    assign w_ch = addr[ADDR_W-1:2];
  end else begin : g_ch_zero
    assign w_ch = '0;
  end

  assign w_reg      = addr[1:0];
  assign w_ch_valid = (32'(w_ch) < NUM_CH);
  assign w_wr       = select && (wr != 4'b0000);

  // Per-channel state
  logic [WIDTH-1:0]  r_count   [NUM_CH];
  logic [WIDTH-1:0]  r_compare [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_periodic;
  logic [NUM_CH-1:0] r_irq_en;
  logic [NUM_CH-1:0] r_pending;

  // Per-channel decoded strobes
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_wr_cmp;
  logic [NUM_CH-1:0] w_wr_ctrl;
  logic [NUM_CH-1:0] w_clear;
  logic [NUM_CH-1:0] w_ack;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_match;
  logic [NUM_CH-1:0] w_fire;
  logic [31:0]       w_cmp_next [NUM_CH];

`ifdef MULTI_TIMER_PRESCALER_EN
  logic [PS_WIDTH-1:0] r_ps     [NUM_CH];
  logic [PS_WIDTH-1:0] r_ps_cnt [NUM_CH];
  logic [NUM_CH-1:0]   w_wr_ps;
`endif

  // Write decode, tick generation and match detection
  always_comb begin
    w_hit     = '0;
    w_wr_cmp  = '0;
    w_wr_ctrl = '0;
    w_clear   = '0;
    w_ack     = '0;
    w_tick    = '0;
    w_match   = '0;
    w_fire    = '0;
`ifdef MULTI_TIMER_PRESCALER_EN
    w_wr_ps   = '0;
`endif
    for (int n = 0; n < NUM_CH; n++) begin
      w_cmp_next[n] = 32'(r_compare[n]);
    end
    for (int n = 0; n < NUM_CH; n++) begin
      w_hit[n]     = w_wr && w_ch_valid && (w_ch == CH_W'(n));
      w_wr_cmp[n]  = w_hit[n] && (w_reg == REG_COMPARE);
      w_wr_ctrl[n] = w_hit[n] && (w_reg == REG_CTRL);
      w_clear[n]   = w_wr_ctrl[n] && data_in[0];
      w_ack[n]     = w_wr_ctrl[n] && data_in[1];
`ifdef MULTI_TIMER_PRESCALER_EN
      w_wr_ps[n]   = w_hit[n] && (w_reg == REG_PRESCALE);
      w_tick[n]    = (r_ps_cnt[n] == r_ps[n]);
`else
      w_tick[n]    = 1'b1;
`endif
      w_match[n]   = (r_count[n] == r_compare[n]);
      // A clear in the same cycle suppresses the match entirely
      w_fire[n]    = w_tick[n] && r_en[n] && w_match[n] && !w_clear[n];
      for (int b = 0; b < 4; b++) begin
        if (wr[b]) begin
          w_cmp_next[n][8*b +: 8] = data_in[8*b +: 8];
        end
      end
    end
  end

  // Channel registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_count[n]   <= '0;
        r_compare[n] <= '1;
      end
      r_en       <= '0;
      r_periodic <= '0;
      r_irq_en   <= '0;
      r_pending  <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_wr_cmp[n]) begin
          r_compare[n] <= WIDTH'(w_cmp_next[n]);
        end

        if (w_wr_ctrl[n]) begin
          r_en[n]       <= data_in[2];
          r_periodic[n] <= data_in[3];
          r_irq_en[n]   <= data_in[4];
        end else if (w_fire[n] && !r_periodic[n]) begin
          r_en[n] <= 1'b0;
        end

        if (w_clear[n]) begin
          r_count[n] <= '0;
        end else if (w_tick[n] && r_en[n]) begin
          r_count[n] <= w_match[n] ? '0 : r_count[n] + WIDTH'(1);
        end

        // A new match outranks an ack in the same cycle
        if (w_fire[n]) begin
          r_pending[n] <= 1'b1;
        end else if (w_ack[n]) begin
          r_pending[n] <= 1'b0;
        end
      end
    end
  end

`ifdef MULTI_TIMER_PRESCALER_EN
  // Prescaler: advances only while the channel is enabled, so a channel
  // enabled from idle starts a full prescale period
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_ps[n]     <= '0;
        r_ps_cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_wr_ps[n]) begin
          r_ps[n] <= data_in[PS_WIDTH-1:0];
        end

        if (w_clear[n] || w_wr_ps[n]) begin
          r_ps_cnt[n] <= '0;
        end else if (r_en[n]) begin
          r_ps_cnt[n] <= w_tick[n] ? '0 : r_ps_cnt[n] + PS_WIDTH'(1);
        end
      end
    end
  end
`endif

  // Read mux; unimplemented channels read 0
  always_comb begin
    data_out = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_ch_valid && (w_ch == CH_W'(n))) begin
        case (w_reg)
          REG_COMPARE:  data_out = 32'(r_compare[n]);
          REG_CTRL:     data_out = {27'b0, r_irq_en[n], r_periodic[n],
                                    r_en[n], r_pending[n], 1'b0};
          REG_COUNT:    data_out = 32'(r_count[n]);
          REG_PRESCALE: begin
`ifdef MULTI_TIMER_PRESCALER_EN
            data_out = 32'(r_ps[n]);
`else
            data_out = '0;
`endif
          end
          default:      data_out = '0;
        endcase
      end
    end
  end

  assign irq_pending = r_pending;
  assign interrupt   = |(r_pending & r_irq_en);

endmodule
